spike_event_detector: RTL and testbench
=======================================

# spike_event_detector

Receive-side counterpart to the mock ADC source. It accepts 16-bit offset-binary ADC samples and converts them to signed. It removes the slow LFP baseline with a first-order IIR and detects negative-going threshold crossings. Each detected spike is emitted as a timestamped, peak-amplitude event on a valid/ready interface toward downstream sorting/logging.

## Interface
- SHIFT, 6: IIR baseline time constant; baseline moves by (x - baseline)/2^SHIFT per sample
- THRESH, 3000: positive magnitude; a crossing occurs when hp <= -THRESH
- REFRACT, 30: samples ignored after each emitted event
- MAX_LEN, 32: max samples in one event before forced emit

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  16  ADC sample, offset binary (0x8000 = 0)
- data_valid  in  1  data_in valid this cycle; no backpressure on input
- spike_valid  out  1  event slot holds an event
- spike_ready  in  1  downstream accepts event
- spike_time  out  32  sample index of the first sample at/below threshold
- spike_amp  out  16  signed minimum hp over the event
- drop_count  out  16  events lost to a full slot; saturates at 0xFFFF

## Operation
- Sample index: 32-bit counter, increments on each data_valid, wraps modulo 2^32. The first sample after reset has index 0.
- Stage 1, on data_valid:
  - x = {~data_in[15], data_in[14:0]} as signed.
  - base_q is signed 24-bit with 8 fractional bits; baseline = base_q[23:8].
  - hp = x - baseline, computed in 17 bits and saturated to [-32768, 32767].
  - base_q <= base_q + (((x <<< 8) - base_q) >>> SHIFT), arithmetic shift, 25-bit intermediate.
  - hp_r, idx_r and hp_v are registered. hp_v is a one-cycle pulse.
- FSM, advancing only when hp_v=1:
  - IDLE: if hp_r <= -THRESH, set t_cap=idx_r, peak=hp_r, len=1, go to PEAK.
  - PEAK: if hp_r < peak, update peak. If hp_r > -THRESH, or len == MAX_LEN, emit {t_cap, peak}, clear rcnt, go to REFRACT. Otherwise len++.
  - REFRACT: rcnt++. Go to IDLE when rcnt reaches REFRACT-1, after REFRACT samples. Crossings are ignored here.
- Emit: load the output slot if spike_valid=0, or if spike_valid&spike_ready in the same cycle. Otherwise drop the event and increment drop_count, saturating. The FSM goes to REFRACT either way.
- Handshake: spike_valid stays high until spike_ready=1 on a clock edge. spike_time and spike_amp are stable while spike_valid=1.

## Timing
- Reset values: spike_valid=0, spike_time=0, spike_amp=0, drop_count=0. Also state=IDLE, base_q=0, index=0, hp_v=0.
- rst mid-event discards any in-flight event and the slot contents. The index restarts at 0.
- Latency: sample S accepted at edge k gives hp_r after edge k. The FSM acts at edge k+1. If S ends an event, spike_valid is high after edge k+1, i.e. 2 clocks.
- Simultaneous drain and emit in one cycle: the new event is loaded and spike_valid stays 1. This is not a drop.
- data_valid gaps freeze the baseline, index and FSM. Back-to-back data_valid every clock is supported.
- A REFRACT of 0 is not supported; REFRACT must be >= 1.

## Test plan
- Constant stream 0x8000 for 1000 samples: spike_valid stays 0, drop_count=0, and the internal baseline stays 0.
- Spike test, spike_ready tied 1:
  - Input 100× 0x8000, then 0x7060 (-4000), 0x31E0 (-20000), 0x6890 (-6000), then 0x8000 continuing.
  - Expect exactly one event: spike_time=100, spike_amp=-19937 (baseline -63 at the second sample).
  - spike_valid rises 2 clocks after the sample at index 103.
- Refractory: a second -20000 sample at index 110, inside REFRACT=30, gives no event. An identical one at index 140 gives an event with spike_time=140.
- Backpressure, spike_ready=0:
  - Three spikes spaced 50 samples apart: the first is held stable, and the next two give drop_count=2.
  - Raise spike_ready for one cycle: spike_valid falls.
- MAX_LEN timeout: hold -10000 for 40 samples starting at index 200. The event is emitted after 32 samples with spike_time=200. Then REFRACT follows, then IDLE, with a new crossing still possible.
- Reset mid-PEAK: assert rst during the event, then feed 0x8000. No event appears, all outputs are 0, and the next sample has index 0.

Source files
------------

// File: rtl/spike_event_detector.sv
// Receive-side spike detector: offset-binary ADC samples are baseline-corrected with a
// first-order IIR, negative threshold crossings are tracked to their peak and emitted as events.
module spike_event_detector #(
  parameter int SHIFT   = 6,
  parameter int THRESH  = 3000,
  parameter int REFRACT = 30,
  parameter int MAX_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic        spike_valid,
  input  logic        spike_ready,
  output logic [31:0] spike_time,
  output logic [15:0] spike_amp,
  output logic [15:0] drop_count
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int RC_W  = $clog2(REFRACT + 1);
  localparam logic signed [15:0] NEG_TH = 16'(-THRESH);

  typedef enum logic [1:0] {
    IDLE,
    PEAK,
    REFR
  } state_t;

  logic        [31:0]      idx_q, idx_d;
  logic signed [23:0]      base_q, base_d;
  logic signed [15:0]      hp_q, hp_d;
  logic        [31:0]      idxr_q, idxr_d;
  logic                    hpv_q, hpv_d;

  state_t                  state_q, state_d;
  logic        [31:0]      tcap_q, tcap_d;
  logic signed [15:0]      peak_q, peak_d;
  logic        [LEN_W-1:0] len_q, len_d;
  logic        [RC_W-1:0]  rcnt_q, rcnt_d;

  logic                    valid_q, valid_d;
  logic        [31:0]      time_q, time_d;
  logic signed [15:0]      amp_q, amp_d;
  logic        [15:0]      drop_q, drop_d;

  logic signed [15:0]      xSigned;
  logic signed [15:0]      baseline;
  logic signed [16:0]      hpWide;
  logic signed [24:0]      baseDiff;
  logic signed [24:0]      baseStep;
  logic signed [15:0]      minHp;
  logic                    emit;
  logic                    slotLoad;

  // Front end: sign conversion, saturated high-pass sample and IIR baseline update.
  always_comb begin
    xSigned  = {~data_in[15], data_in[14:0]};
    baseline = base_q[23:8];
    hpWide   = {xSigned[15], xSigned} - {baseline[15], baseline};
    baseDiff = {xSigned[15], xSigned, 8'h00} - {base_q[23], base_q};
    baseStep = baseDiff >>> SHIFT;

    idx_d  = idx_q;
    base_d = base_q;
    hp_d   = hp_q;
    idxr_d = idxr_q;
    hpv_d  = 1'b0;
    if (data_valid) begin
      if (hpWide[16] != hpWide[15]) begin
        hp_d = hpWide[16] ? 16'sh8000 : 16'sh7FFF;
      end else begin
        hp_d = hpWide[15:0];
      end
      base_d = 24'({base_q[23], base_q} + baseStep);
      idxr_d = idx_q;
      idx_d  = idx_q + 32'd1;
      hpv_d  = 1'b1;
    end
  end

  // Event tracker and output slot; the peak includes the sample that closes the event.
  always_comb begin
    state_d  = state_q;
    tcap_d   = tcap_q;
    peak_d   = peak_q;
    len_d    = len_q;
    rcnt_d   = rcnt_q;
    emit     = 1'b0;
    minHp    = (hp_q < peak_q) ? hp_q : peak_q;

    if (hpv_q) begin
      case (state_q)
        IDLE: begin
          if (hp_q <= NEG_TH) begin
            tcap_d  = idxr_q;
            peak_d  = hp_q;
            len_d   = LEN_W'(1);
            state_d = PEAK;
          end
        end
        PEAK: begin
          peak_d = minHp;
          if (hp_q > NEG_TH || len_q == LEN_W'(MAX_LEN)) begin
            emit    = 1'b1;
            rcnt_d  = '0;
            state_d = REFR;
          end else begin
            len_d = len_q + LEN_W'(1);
          end
        end
        REFR: begin
          if (rcnt_q == RC_W'(REFRACT - 1)) begin
            rcnt_d  = '0;
            state_d = IDLE;
          end else begin
            rcnt_d = rcnt_q + RC_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    slotLoad = emit && (!valid_q || spike_ready);
    valid_d  = valid_q;
    time_d   = time_q;
    amp_d    = amp_q;
    drop_d   = drop_q;
    if (slotLoad) begin
      valid_d = 1'b1;
      time_d  = tcap_q;
      amp_d   = minHp;
    end else if (spike_ready) begin
      valid_d = 1'b0;
    end
    if (emit && !slotLoad && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      base_q  <= '0;
      hp_q    <= '0;
      idxr_q  <= '0;
      hpv_q   <= 1'b0;
      state_q <= IDLE;
      tcap_q  <= '0;
      peak_q  <= '0;
      len_q   <= '0;
      rcnt_q  <= '0;
      valid_q <= 1'b0;
      time_q  <= '0;
      amp_q   <= '0;
      drop_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      base_q  <= base_d;
      hp_q    <= hp_d;
      idxr_q  <= idxr_d;
      hpv_q   <= hpv_d;
      state_q <= state_d;
      tcap_q  <= tcap_d;
      peak_q  <= peak_d;
      len_q   <= len_d;
      rcnt_q  <= rcnt_d;
      valid_q <= valid_d;
      time_q  <= time_d;
      amp_q   <= amp_d;
      drop_q  <= drop_d;
    end
  end

  assign spike_valid = valid_q;
  assign spike_time  = time_q;
  assign spike_amp   = amp_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_spike_event_detector.sv
// Self-checking bench for spike_event_detector: directed vector table, corner-case sequences
// and randomized traffic, all compared every cycle against an integer reference model.
module tb_spike_event_detector;

  localparam int SHIFT   = 6;
  localparam int THRESH  = 3000;
  localparam int REFRACT = 30;
  localparam int MAX_LEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        data_valid;
  logic        spike_valid;
  logic        spike_ready;
  logic [31:0] spike_time;
  logic [15:0] spike_amp;
  logic [15:0] drop_count;

  int assertCount = 0;
  int failCount   = 0;

  spike_event_detector #(
    .SHIFT(SHIFT), .THRESH(THRESH), .REFRACT(REFRACT), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_time(spike_time),
    .spike_amp(spike_amp), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: baseline kept as an integer scaled by 256, events as plain counters.
  int          mBase;
  logic [31:0] mIdx;
  bit          mPendValid;
  int          mPendHp;
  logic [31:0] mPendIdx;
  bit          mEvActive;
  logic [31:0] mEvStart;
  int          mEvMin;
  int          mEvCount;
  int          mQuiet;
  bit          mSlotValid;
  logic [31:0] mSlotTime;
  int          mSlotAmp;
  int          mDrops;

  typedef struct {
    bit          rstIn;
    bit          dvIn;
    logic [15:0] dataIn;
    bit          readyIn;
    int          repeatN;
    bit          expValid;
    logic [31:0] expTime;
    logic [15:0] expAmp;
    logic [15:0] expDrop;
    bit          checkAmp;
  } vecT;

  function automatic int floorDiv(int a, int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  task automatic modelReset();
    mBase = 0; mIdx = 0; mPendValid = 0; mPendHp = 0; mPendIdx = 0;
    mEvActive = 0; mEvStart = 0; mEvMin = 0; mEvCount = 0; mQuiet = 0;
    mSlotValid = 0; mSlotTime = 0; mSlotAmp = 0; mDrops = 0;
  endtask

  task automatic modelEdge(bit r, bit dv, logic [15:0] d, bit rdy);
    bit          emit;
    logic [31:0] eTime;
    int          eAmp;
    int          x;
    int          hp;
    if (r) begin
      modelReset();
      return;
    end
    emit = 0; eTime = 0; eAmp = 0;
    if (mPendValid) begin
      if (mQuiet > 0) begin
        mQuiet--;
      end else if (!mEvActive) begin
        if (mPendHp <= -THRESH) begin
          mEvActive = 1; mEvStart = mPendIdx; mEvMin = mPendHp; mEvCount = 1;
        end
      end else begin
        if (mPendHp < mEvMin) mEvMin = mPendHp;
        if (mPendHp > -THRESH || mEvCount == MAX_LEN) begin
          emit = 1; eTime = mEvStart; eAmp = mEvMin;
          mEvActive = 0; mQuiet = REFRACT;
        end else begin
          mEvCount++;
        end
      end
    end
    if (emit) begin
      if (!mSlotValid || rdy) begin
        mSlotValid = 1; mSlotTime = eTime; mSlotAmp = eAmp;
      end else if (mDrops < 65535) begin
        mDrops++;
      end
    end else if (rdy) begin
      mSlotValid = 0;
    end
    if (dv) begin
      x  = int'(d) - 32768;
      hp = x - floorDiv(mBase, 256);
      if (hp > 32767) hp = 32767;
      if (hp < -32768) hp = -32768;
      mPendHp = hp; mPendIdx = mIdx; mPendValid = 1;
      mBase = mBase + floorDiv(x * 256 - mBase, 1 << SHIFT);
      mIdx  = mIdx + 1;
    end else begin
      mPendValid = 0;
    end
  endtask

  task automatic compareVal(string name, logic [31:0] act, logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(string tag);
    compareVal({tag, ".valid"}, {31'd0, spike_valid}, {31'd0, mSlotValid});
    compareVal({tag, ".time"}, spike_time, mSlotTime);
    compareVal({tag, ".amp"}, {16'd0, spike_amp}, {16'd0, 16'(mSlotAmp)});
    compareVal({tag, ".drop"}, {16'd0, drop_count}, 32'(mDrops));
  endtask

  // One clock: drive inputs away from the edge, advance the model, compare after the edge.
  task automatic applyStimulus(bit r, bit dv, logic [15:0] d, bit rdy, string tag);
    rst = r; data_valid = dv; data_in = d; spike_ready = rdy;
    @(posedge clk);
    #1;
    modelEdge(r, dv, d, rdy);
    checkOutput(tag);
  endtask

  task automatic feed(logic [15:0] d, int n, bit rdy, string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, d, rdy, tag);
  endtask

  task automatic expectSlot(string tag, bit v, logic [31:0] t, logic [15:0] a, logic [15:0] dr);
    compareVal({tag, ".expValid"}, {31'd0, spike_valid}, {31'd0, v});
    compareVal({tag, ".expTime"}, spike_time, t);
    compareVal({tag, ".expAmp"}, {16'd0, spike_amp}, {16'd0, a});
    compareVal({tag, ".expDrop"}, {16'd0, drop_count}, {16'd0, dr});
  endtask

  function automatic vecT mkVec(bit r, bit dv, logic [15:0] d, bit rdy, int n,
                                bit v, logic [31:0] t, logic [15:0] a, logic [15:0] dr, bit ca);
    vecT w;
    w.rstIn = r; w.dvIn = dv; w.dataIn = d; w.readyIn = rdy; w.repeatN = n;
    w.expValid = v; w.expTime = t; w.expAmp = a; w.expDrop = dr; w.checkAmp = ca;
    return w;
  endfunction

  vecT vecs[15];

  initial begin
    vecT w;
    string tag;
    bit r, dv, rdy;
    logic [15:0] d;
    int pick;

    vecs[0]  = mkVec(1, 0, 16'h8000, 1, 2,    0, 32'd0,   16'h0000, 16'd0, 1);
    vecs[1]  = mkVec(0, 1, 16'h8000, 1, 1000, 0, 32'd0,   16'h0000, 16'd0, 1);
    vecs[2]  = mkVec(1, 1, 16'h8000, 1, 1,    0, 32'd0,   16'h0000, 16'd0, 1);
    vecs[3]  = mkVec(0, 1, 16'h8000, 1, 100,  0, 32'd0,   16'h0000, 16'd0, 1);
    vecs[4]  = mkVec(0, 1, 16'h7060, 1, 1,    0, 32'd0,   16'h0000, 16'd0, 1);
    vecs[5]  = mkVec(0, 1, 16'h31E0, 1, 1,    0, 32'd0,   16'h0000, 16'd0, 1);
    vecs[6]  = mkVec(0, 1, 16'h6890, 1, 1,    0, 32'd0,   16'h0000, 16'd0, 1);
    vecs[7]  = mkVec(0, 1, 16'h8000, 1, 1,    0, 32'd0,   16'h0000, 16'd0, 1);
    vecs[8]  = mkVec(0, 1, 16'h8000, 1, 1,    1, 32'd100, 16'hB21F, 16'd0, 1);
    vecs[9]  = mkVec(0, 1, 16'h8000, 1, 5,    0, 32'd100, 16'hB21F, 16'd0, 1);
    vecs[10] = mkVec(0, 1, 16'h31E0, 1, 1,    0, 32'd100, 16'hB21F, 16'd0, 1);
    vecs[11] = mkVec(0, 1, 16'h8000, 1, 29,   0, 32'd100, 16'hB21F, 16'd0, 1);
    vecs[12] = mkVec(0, 1, 16'h31E0, 1, 1,    0, 32'd100, 16'hB21F, 16'd0, 1);
    vecs[13] = mkVec(0, 1, 16'h8000, 1, 1,    0, 32'd100, 16'hB21F, 16'd0, 1);
    vecs[14] = mkVec(0, 1, 16'h8000, 1, 1,    1, 32'd140, 16'h0000, 16'd0, 0);

    modelReset();
    rst = 1'b1; data_valid = 1'b0; data_in = 16'h8000; spike_ready = 1'b1;

    for (int i = 0; i < 15; i++) begin
      w = vecs[i];
      tag = $sformatf("row%0d", i);
      for (int n = 0; n < w.repeatN; n++) applyStimulus(w.rstIn, w.dvIn, w.dataIn, w.readyIn, tag);
      compareVal({tag, ".valid"}, {31'd0, spike_valid}, {31'd0, w.expValid});
      compareVal({tag, ".time"}, spike_time, w.expTime);
      compareVal({tag, ".drop"}, {16'd0, drop_count}, {16'd0, w.expDrop});
      if (w.checkAmp) compareVal({tag, ".amp"}, {16'd0, spike_amp}, {16'd0, w.expAmp});
    end

    // Backpressure: first event held, the next two are dropped.
    applyStimulus(1, 0, 16'h8000, 0, "bpReset");
    feed(16'h8000, 20, 0, "bpLead");
    for (int s = 0; s < 3; s++) begin
      feed(16'h31E0, 1, 0, "bpSpike");
      feed(16'h8000, 49, 0, "bpQuiet");
      if (s == 0) expectSlot("bpHeld", 1, 32'd20, 16'hB1E0, 16'd0);
    end
    expectSlot("bpDropped", 1, 32'd20, 16'hB1E0, 16'd2);
    applyStimulus(0, 1, 16'h8000, 1, "bpDrain");
    expectSlot("bpDrained", 0, 32'd20, 16'hB1E0, 16'd2);

    // Forced emit after MAX_LEN samples, then refractory, then a fresh crossing.
    applyStimulus(1, 0, 16'h8000, 1, "mlReset");
    feed(16'h8000, 200, 1, "mlLead");
    feed(16'h58F0, 33, 1, "mlHold");
    expectSlot("mlBeforeEmit", 0, 32'd0, 16'h0000, 16'd0);
    feed(16'h58F0, 1, 1, "mlHold");
    expectSlot("mlEmit", 1, 32'd200, 16'hD8F0, 16'd0);
    feed(16'h58F0, 6, 1, "mlHold");
    feed(16'h8000, 60, 1, "mlRecover");
    feed(16'h31E0, 1, 1, "mlSpike");
    feed(16'h8000, 2, 1, "mlTail");
    compareVal("mlSecond.valid", {31'd0, spike_valid}, 32'd1);
    compareVal("mlSecond.time", spike_time, 32'd300);

    // Reset in the middle of an event, then an input gap, then index restarts at 0.
    applyStimulus(1, 0, 16'h8000, 1, "rpReset");
    feed(16'h8000, 10, 1, "rpLead");
    feed(16'h31E0, 2, 1, "rpPeak");
    applyStimulus(1, 1, 16'h8000, 1, "rpMidReset");
    expectSlot("rpCleared", 0, 32'd0, 16'h0000, 16'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 16'h31E0, 1, "rpGap");
    feed(16'h8000, 5, 1, "rpLead2");
    expectSlot("rpQuiet", 0, 32'd0, 16'h0000, 16'd0);
    feed(16'h31E0, 1, 1, "rpSpike");
    feed(16'h8000, 2, 1, "rpTail");
    expectSlot("rpIndex", 1, 32'd5, 16'hB1E0, 16'd0);

    // Saturation: high baseline followed by full-scale negative sample clips hp to -32768.
    applyStimulus(1, 0, 16'h8000, 1, "satReset");
    feed(16'hFFFF, 400, 1, "satHigh");
    feed(16'h0000, 1, 1, "satLow");
    feed(16'hFFFF, 2, 1, "satEnd");
    expectSlot("satAmp", 1, 32'd400, 16'h8000, 16'd0);

    // Randomized traffic with gaps, backpressure and rare resets.
    applyStimulus(1, 0, 16'h8000, 1, "rndReset");
    for (int c = 0; c < 4000; c++) begin
      r   = ($urandom_range(0, 1999) == 0);
      dv  = ($urandom_range(0, 9) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 99);
      if (pick < 3)      d = 16'(32768 - $urandom_range(3000, 25000));
      else if (pick < 5) d = 16'($urandom_range(0, 65535));
      else               d = 16'(32768 + $urandom_range(0, 1000) - 500);
      applyStimulus(r, dv, d, rdy, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
